// File: rtl/read_return_buffer.sv
// Read-return buffer: pairs data beats from several sources with scheduler IDs
// in a shared entry array and returns complete {data, tid} pairs in order.
module read_return_buffer #(
   parameter int DEPTH        = 64,
   parameter int LOG2_DEPTH   = 6,
   parameter int DATA_SIZE    = 64,
   parameter int TID_SIZE     = 2,
   parameter int NUM_SRC      = 2,
   parameter int AFULL_THRESH = 60
) (
   input  logic                          i_clk,
   input  logic                          i_n_rst,
   input  logic [NUM_SRC-1:0]            i_src_strobe,
   input  logic [NUM_SRC*DATA_SIZE-1:0]  i_src_data,
   input  logic                          i_tid_strobe,
   input  logic [TID_SIZE-1:0]           i_tid_push,
   input  logic                          i_flush,
   input  logic                          i_err_clr,
   input  logic                          i_rready,
   output logic                          o_rvalid,
   output logic [DATA_SIZE-1:0]          o_rdata,
   output logic [TID_SIZE-1:0]           o_tid_out,
   output logic [LOG2_DEPTH:0]           o_data_count,
   output logic [LOG2_DEPTH:0]           o_tid_count,
   output logic                          o_almost_full,
   output logic                          o_err_overflow,
   output logic                          o_err_collision
);
   localparam int CW = LOG2_DEPTH + 1;

   logic [DATA_SIZE-1:0]  r_data_mem [DEPTH];
   logic [TID_SIZE-1:0]   r_tid_mem  [DEPTH];
   logic [LOG2_DEPTH-1:0] r_dwptr, r_twptr, r_rptr;
   logic [CW-1:0]         r_data_count, r_tid_count;
   logic                  r_almost_full, r_err_overflow, r_err_collision;

   logic [DATA_SIZE-1:0]  w_sel_data;
   logic                  w_any_strobe, w_multi_strobe;
   logic                  w_dfull, w_tfull, w_dwr, w_twr, w_pop;
   logic                  w_ovf, w_dcnt_af, w_tcnt_af;
   logic [CW-1:0]         w_dcnt_nxt, w_tcnt_nxt;

   // Descending scan so the lowest-index asserted source wins.
   always_comb begin
      w_sel_data = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--)
         if (i_src_strobe[i]) w_sel_data = i_src_data[i*DATA_SIZE +: DATA_SIZE];
   end

   assign w_any_strobe   = |i_src_strobe;
   assign w_multi_strobe = |(i_src_strobe & (i_src_strobe - 1'b1));
   assign w_dfull        = (r_data_count == CW'(DEPTH));
   assign w_tfull        = (r_tid_count  == CW'(DEPTH));
   assign w_dwr          = w_any_strobe && !w_dfull;
   assign w_twr          = i_tid_strobe && !w_tfull;
   assign w_pop          = o_rvalid && i_rready;
   assign w_ovf          = (w_any_strobe && w_dfull) || (i_tid_strobe && w_tfull);

   // Full is judged on the registered count, so a same-cycle pop never frees room.
   assign w_dcnt_nxt = r_data_count + CW'(w_dwr) - CW'(w_pop);
   assign w_tcnt_nxt = r_tid_count  + CW'(w_twr) - CW'(w_pop);
   assign w_dcnt_af  = (w_dcnt_nxt >= CW'(AFULL_THRESH));
   assign w_tcnt_af  = (w_tcnt_nxt >= CW'(AFULL_THRESH));

   always_ff @(posedge i_clk) begin
      if (!i_n_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_data_mem[i] <= '0;
            r_tid_mem[i]  <= '0;
         end
         r_dwptr         <= '0;
         r_twptr         <= '0;
         r_rptr          <= '0;
         r_data_count    <= '0;
         r_tid_count     <= '0;
         r_almost_full   <= 1'b0;
         r_err_overflow  <= 1'b0;
         r_err_collision <= 1'b0;
      end else begin
         if (i_flush) begin
            r_dwptr       <= '0;
            r_twptr       <= '0;
            r_rptr        <= '0;
            r_data_count  <= '0;
            r_tid_count   <= '0;
            r_almost_full <= 1'b0;
         end else begin
            if (w_dwr) begin
               r_data_mem[r_dwptr] <= w_sel_data;
               r_dwptr             <= r_dwptr + 1'b1;
            end
            if (w_twr) begin
               r_tid_mem[r_twptr] <= i_tid_push;
               r_twptr            <= r_twptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            r_data_count  <= w_dcnt_nxt;
            r_tid_count   <= w_tcnt_nxt;
            r_almost_full <= w_dcnt_af || w_tcnt_af;
         end
         // Set has priority over clear.
         r_err_overflow  <= (r_err_overflow  && !i_err_clr) || w_ovf;
         r_err_collision <= (r_err_collision && !i_err_clr) || w_multi_strobe;
      end
   end

   assign o_rvalid        = (r_data_count != '0) && (r_tid_count != '0);
   assign o_rdata         = r_data_mem[r_rptr];
   assign o_tid_out       = r_tid_mem[r_rptr];
   assign o_data_count    = r_data_count;
   assign o_tid_count     = r_tid_count;
   assign o_almost_full   = r_almost_full;
   assign o_err_overflow  = r_err_overflow;
   assign o_err_collision = r_err_collision;
endmodule

// File: tb/tb_read_return_buffer.sv
// Directed bench for read_return_buffer: pairing, fill/overflow, streaming,
// collision, flush and mid-stream reset.
module tb_read_return_buffer;
   logic         clk = 1'b0;
   logic         n_rst;
   logic [1:0]   src_strobe;
   logic [127:0] src_data;
   logic         tid_strobe;
   logic [1:0]   tid_push;
   logic         flush, err_clr, rready;
   logic         rvalid;
   logic [63:0]  rdata;
   logic [1:0]   tid_out;
   logic [6:0]   data_count, tid_count;
   logic         almost_full, err_overflow, err_collision;

   int errors = 0;
   int checks = 0;

   read_return_buffer dut (
      .i_clk(clk), .i_n_rst(n_rst), .i_src_strobe(src_strobe), .i_src_data(src_data),
      .i_tid_strobe(tid_strobe), .i_tid_push(tid_push), .i_flush(flush),
      .i_err_clr(err_clr), .i_rready(rready), .o_rvalid(rvalid), .o_rdata(rdata),
      .o_tid_out(tid_out), .o_data_count(data_count), .o_tid_count(tid_count),
      .o_almost_full(almost_full), .o_err_overflow(err_overflow),
      .o_err_collision(err_collision)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      src_strobe = 2'b00; src_data = '0; tid_strobe = 1'b0; tid_push = 2'd0;
      flush = 1'b0; err_clr = 1'b0; rready = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      n_rst = 1'b0;
      tick();
      n_rst = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (rvalid !== 1'b0 || data_count !== 7'd0 || tid_count !== 7'd0 ||
          almost_full !== 1'b0 || err_overflow !== 1'b0 || err_collision !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: rvalid=%b dc=%0d tc=%0d af=%b ovf=%b col=%b, want all 0",
                  rvalid, data_count, tid_count, almost_full, err_overflow, err_collision);
      end
   endtask

   task automatic test_basic_pair();
      do_reset();
      src_strobe = 2'b01; src_data[63:0] = 64'hA5;
      tick();
      idle();
      checks++;
      if (rvalid !== 1'b0) begin errors++; $display("FAIL pair_c1_rvalid: got %b want 0", rvalid); end
      tick();
      checks++;
      if (rvalid !== 1'b0) begin errors++; $display("FAIL pair_c2_rvalid: got %b want 0", rvalid); end
      tid_strobe = 1'b1; tid_push = 2'd2;
      tick();
      idle();
      checks++;
      if (rvalid !== 1'b1 || rdata !== 64'hA5 || tid_out !== 2'd2 ||
          data_count !== 7'd1 || tid_count !== 7'd1) begin
         errors++;
         $display("FAIL pair_visible: rvalid=%b rdata=%h tid=%0d dc=%0d tc=%0d want 1 a5 2 1 1",
                  rvalid, rdata, tid_out, data_count, tid_count);
      end
   endtask

   task automatic test_fill_overflow();
      do_reset();
      for (int i = 0; i < 64; i++) begin
         src_strobe = 2'b01; src_data[63:0] = 64'h100 + 64'(i);
         tid_strobe = 1'b1; tid_push = 2'(i);
         tick();
         if (i == 58) begin
            checks++;
            if (almost_full !== 1'b0) begin errors++; $display("FAIL afull_59: got %b want 0", almost_full); end
         end
         if (i == 59) begin
            checks++;
            if (almost_full !== 1'b1) begin errors++; $display("FAIL afull_60: got %b want 1", almost_full); end
         end
      end
      idle();
      checks++;
      if (data_count !== 7'd64 || tid_count !== 7'd64 || err_overflow !== 1'b0) begin
         errors++;
         $display("FAIL fill_64: dc=%0d tc=%0d ovf=%b want 64 64 0", data_count, tid_count, err_overflow);
      end
      src_strobe = 2'b01; src_data[63:0] = 64'hDEAD;
      tick();
      idle();
      checks++;
      if (data_count !== 7'd64 || err_overflow !== 1'b1 || rdata !== 64'h100) begin
         errors++;
         $display("FAIL overflow_drop: dc=%0d ovf=%b head=%h want 64 1 100", data_count, err_overflow, rdata);
      end
      err_clr = 1'b1;
      tick();
      idle();
      checks++;
      if (err_overflow !== 1'b0) begin errors++; $display("FAIL err_clr: ovf=%b want 0", err_overflow); end
      rready = 1'b1;
      for (int i = 0; i < 64; i++) begin
         checks++;
         if (rvalid !== 1'b1 || rdata !== 64'h100 + 64'(i) || tid_out !== 2'(i)) begin
            errors++;
            $display("FAIL drain[%0d]: rvalid=%b rdata=%h tid=%0d want 1 %h %0d",
                     i, rvalid, rdata, tid_out, 64'h100 + 64'(i), i % 4);
         end
         tick();
      end
      idle();
      checks++;
      if (rvalid !== 1'b0 || data_count !== 7'd0 || almost_full !== 1'b0) begin
         errors++;
         $display("FAIL drained: rvalid=%b dc=%0d af=%b want 0 0 0", rvalid, data_count, almost_full);
      end
   endtask

   task automatic test_streaming();
      do_reset();
      rready = 1'b1;
      for (int k = 0; k < 200; k++) begin
         src_strobe = 2'b01; src_data[63:0] = 64'h5000 + 64'(k * 3);
         tid_strobe = 1'b1; tid_push = 2'(k);
         tick();
         checks++;
         if (rvalid !== 1'b1 || rdata !== 64'h5000 + 64'(k * 3) || tid_out !== 2'(k) ||
             data_count !== 7'd1 || tid_count !== 7'd1) begin
            errors++;
            $display("FAIL stream[%0d]: rvalid=%b rdata=%h tid=%0d dc=%0d tc=%0d want 1 %h %0d 1 1",
                     k, rvalid, rdata, tid_out, data_count, tid_count, 64'h5000 + 64'(k * 3), k % 4);
         end
      end
      idle();
   endtask

   task automatic test_collision();
      do_reset();
      src_strobe = 2'b11; src_data = {64'h22, 64'h11};
      tick();
      idle();
      checks++;
      if (data_count !== 7'd1 || err_collision !== 1'b1 || err_overflow !== 1'b0) begin
         errors++;
         $display("FAIL collision_flags: dc=%0d col=%b ovf=%b want 1 1 0", data_count, err_collision, err_overflow);
      end
      tid_strobe = 1'b1; tid_push = 2'd1;
      tick();
      idle();
      checks++;
      if (rvalid !== 1'b1 || rdata !== 64'h11 || tid_out !== 2'd1) begin
         errors++;
         $display("FAIL collision_data: rvalid=%b rdata=%h tid=%0d want 1 11 1", rvalid, rdata, tid_out);
      end
   endtask

   task automatic test_flush();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         src_strobe = (i == 0) ? 2'b11 : 2'b01;
         src_data = {64'hEE, 64'h300 + 64'(i)};
         tid_strobe = (i < 3); tid_push = 2'(i);
         tick();
      end
      idle();
      checks++;
      if (data_count !== 7'd5 || tid_count !== 7'd3 || err_collision !== 1'b1) begin
         errors++;
         $display("FAIL partial_fill: dc=%0d tc=%0d col=%b want 5 3 1", data_count, tid_count, err_collision);
      end
      flush = 1'b1; src_strobe = 2'b01; src_data[63:0] = 64'h999;
      tick();
      idle();
      checks++;
      if (data_count !== 7'd0 || tid_count !== 7'd0 || rvalid !== 1'b0 ||
          err_collision !== 1'b1 || err_overflow !== 1'b0 || almost_full !== 1'b0) begin
         errors++;
         $display("FAIL flush: dc=%0d tc=%0d rvalid=%b col=%b ovf=%b af=%b want 0 0 0 1 0 0",
                  data_count, tid_count, rvalid, err_collision, err_overflow, almost_full);
      end
      src_strobe = 2'b01; src_data[63:0] = 64'h77; tid_strobe = 1'b1; tid_push = 2'd1;
      tick();
      idle();
      checks++;
      if (rvalid !== 1'b1 || rdata !== 64'h77 || tid_out !== 2'd1 ||
          data_count !== 7'd1 || tid_count !== 7'd1) begin
         errors++;
         $display("FAIL post_flush: rvalid=%b rdata=%h tid=%0d dc=%0d tc=%0d want 1 77 1 1 1",
                  rvalid, rdata, tid_out, data_count, tid_count);
      end
   endtask

   task automatic test_midreset();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         src_strobe = (i == 0) ? 2'b11 : 2'b01;
         src_data = {64'hEE, 64'h400 + 64'(i)};
         tid_strobe = 1'b1; tid_push = 2'(i);
         tick();
      end
      checks++;
      if (data_count !== 7'd10 || tid_count !== 7'd10 || err_collision !== 1'b1) begin
         errors++;
         $display("FAIL held_10: dc=%0d tc=%0d col=%b want 10 10 1", data_count, tid_count, err_collision);
      end
      n_rst = 1'b0; flush = 1'b1; rready = 1'b1;
      tick();
      checks++;
      if (rvalid !== 1'b0 || rdata !== 64'd0 || tid_out !== 2'd0 || data_count !== 7'd0 ||
          tid_count !== 7'd0 || almost_full !== 1'b0 || err_overflow !== 1'b0 || err_collision !== 1'b0) begin
         errors++;
         $display("FAIL midreset: rvalid=%b rdata=%h tid=%0d dc=%0d tc=%0d af=%b ovf=%b col=%b want all 0",
                  rvalid, rdata, tid_out, data_count, tid_count, almost_full, err_overflow, err_collision);
      end
      n_rst = 1'b1;
      idle();
      src_strobe = 2'b01; src_data[63:0] = 64'hBEEF; tid_strobe = 1'b1; tid_push = 2'd3;
      tick();
      idle();
      checks++;
      if (rvalid !== 1'b1 || rdata !== 64'hBEEF || tid_out !== 2'd3 || data_count !== 7'd1) begin
         errors++;
         $display("FAIL post_reset: rvalid=%b rdata=%h tid=%0d dc=%0d want 1 beef 3 1",
                  rvalid, rdata, tid_out, data_count);
      end
   endtask

   initial begin
      n_rst = 1'b1;
      idle();
      test_reset();
      test_basic_pair();
      test_fill_overflow();
      test_streaming();
      test_collision();
      test_flush();
      test_midreset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
